// File: rtl/trbds3_dio_pkg.sv
// Shared definitions for the DIO trigger/pulse path: channel FSM encoding and default widths.
package trbds3_dio_pkg;

  localparam int unsigned DefDlyW = 24;
  localparam int unsigned DefWidW = 24;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDelay = 2'd1,
    StPulse = 2'd2
  } ch_state_e;

  function automatic int unsigned max_w(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/do_pulse_ch.sv
// One delayed-pulse channel: latches delay/width on start, waits delay cycles, then pulses.
module do_pulse_ch
  import trbds3_dio_pkg::*;
#(
  parameter int unsigned DlyW = DefDlyW,
  parameter int unsigned WidW = DefWidW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [DlyW-1:0] delay_i,
  input  logic [WidW-1:0] width_i,
  output logic            pulse_o,
  output logic            busy_o
);

  localparam int unsigned CntW = max_w(DlyW, WidW);

  ch_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [WidW-1:0] wid_q, wid_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && (width_i != '0)) begin
          wid_d = width_i;
          if (delay_i == '0) begin
            state_d = StPulse;
            cnt_d   = CntW'(width_i);
          end else begin
            state_d = StDelay;
            cnt_d   = CntW'(delay_i);
          end
        end
      end
      StDelay: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StPulse;
          cnt_d   = CntW'(wid_q);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StPulse: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything, including a start in the same cycle.
    if (abort_i) begin
      state_d = StIdle;
    end
    pulse_d = (state_d == StPulse);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wid_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign busy_o  = (state_q != StIdle);

endmodule

// File: rtl/trg_pulse_gen.sv
// Beam-trigger pulse generator: synchronizes the external trigger and fans accepted events
// out to the trigger channel and four delayed pulse channels.
module trg_pulse_gen
  import trbds3_dio_pkg::*;
#(
  parameter int unsigned DLY_W    = DefDlyW,
  parameter int unsigned WID_W    = DefWidW,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_beam_trg,
  input  logic             i_enable,
  input  logic             i_interlock,
  input  logic [WID_W-1:0] i_trg_width,
  input  logic [DLY_W-1:0] i_ch1_delay,
  input  logic [WID_W-1:0] i_ch1_width,
  input  logic [DLY_W-1:0] i_ch2_delay,
  input  logic [WID_W-1:0] i_ch2_width,
  input  logic [DLY_W-1:0] i_ch3_delay,
  input  logic [WID_W-1:0] i_ch3_width,
  input  logic [DLY_W-1:0] i_ch4_delay,
  input  logic [WID_W-1:0] i_ch4_width,
  output logic             o_do_trg,
  output logic             o_do_ch1,
  output logic             o_do_ch2,
  output logic             o_do_ch3,
  output logic             o_do_ch4,
  output logic             o_do_interlock,
  output logic             o_busy,
  output logic [31:0]      o_trg_cnt,
  output logic [31:0]      o_miss_cnt
);

  // SYNC_STG must be at least 2.
  logic [SYNC_STG-1:0] sync_q;
  logic                hist_q;
  logic                ev_q;
  logic                ilk_q;
  logic [31:0]         trg_cnt_q, trg_cnt_d;
  logic [31:0]         miss_cnt_q, miss_cnt_d;
  logic                armed;
  logic                accept;
  logic                miss;
  logic [4:0]          ch_pulse;
  logic [4:0]          ch_busy;
  logic [DLY_W-1:0]    ch_dly [4];
  logic [WID_W-1:0]    ch_wid [4];

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
      ev_q   <= 1'b0;
      ilk_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], i_beam_trg};
      hist_q <= sync_q[SYNC_STG-1];
      ev_q   <= sync_q[SYNC_STG-1] & ~hist_q;
      ilk_q  <= i_interlock;
    end
  end

  assign armed  = ev_q & i_enable & ~i_interlock;
  assign accept = armed & ~o_busy;
  assign miss   = armed & o_busy;

  always_comb begin
    trg_cnt_d  = trg_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept) begin
      trg_cnt_d = trg_cnt_q + 32'd1;
    end
    if (miss) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      trg_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      trg_cnt_q  <= trg_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign ch_dly[0] = i_ch1_delay;
  assign ch_dly[1] = i_ch2_delay;
  assign ch_dly[2] = i_ch3_delay;
  assign ch_dly[3] = i_ch4_delay;
  assign ch_wid[0] = i_ch1_width;
  assign ch_wid[1] = i_ch2_width;
  assign ch_wid[2] = i_ch3_width;
  assign ch_wid[3] = i_ch4_width;

  // The trigger output is a channel whose delay is tied to zero.
  do_pulse_ch #(
    .DlyW(DLY_W),
    .WidW(WID_W)
  ) u_ch_trg (
    .clk_i  (i_clk),
    .rst_ni (i_rstn),
    .start_i(accept),
    .abort_i(i_interlock),
    .delay_i({DLY_W{1'b0}}),
    .width_i(i_trg_width),
    .pulse_o(ch_pulse[0]),
    .busy_o (ch_busy[0])
  );

  for (genvar g = 0; g < 4; g++) begin : g_ch
    do_pulse_ch #(
      .DlyW(DLY_W),
      .WidW(WID_W)
    ) u_ch (
      .clk_i  (i_clk),
      .rst_ni (i_rstn),
      .start_i(accept),
      .abort_i(i_interlock),
      .delay_i(ch_dly[g]),
      .width_i(ch_wid[g]),
      .pulse_o(ch_pulse[g+1]),
      .busy_o (ch_busy[g+1])
    );
  end

  assign o_do_trg       = ch_pulse[0];
  assign o_do_ch1       = ch_pulse[1];
  assign o_do_ch2       = ch_pulse[2];
  assign o_do_ch3       = ch_pulse[3];
  assign o_do_ch4       = ch_pulse[4];
  assign o_do_interlock = ilk_q;
  assign o_busy         = |ch_busy;
  assign o_trg_cnt      = trg_cnt_q;
  assign o_miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_trg_pulse_gen.sv
// Self-checking bench for trg_pulse_gen: vector table, directed corner sequences and
// randomized traffic checked every cycle against an event-window reference model.
`timescale 1ns / 1ps
module tb_trg_pulse_gen;

  localparam int unsigned DW  = 24;
  localparam int unsigned WW  = 24;
  localparam int unsigned STG = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          beam = 1'b0;
  logic          en = 1'b0;
  logic          ilk = 1'b0;
  logic [WW-1:0] trg_w = '0;
  logic [DW-1:0] dly [4];
  logic [WW-1:0] wid [4];
  logic          do_trg, do_ch1, do_ch2, do_ch3, do_ch4, do_ilk, busy;
  logic [31:0]   trg_cnt, miss_cnt;

  int asserts = 0;
  int errors  = 0;
  bit force_req = 1'b0;

  always #2.5 clk = ~clk;

  trg_pulse_gen #(
    .DLY_W   (DW),
    .WID_W   (WW),
    .SYNC_STG(STG)
  ) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_beam_trg    (beam),
    .i_enable      (en),
    .i_interlock   (ilk),
    .i_trg_width   (trg_w),
    .i_ch1_delay   (dly[0]),
    .i_ch1_width   (wid[0]),
    .i_ch2_delay   (dly[1]),
    .i_ch2_width   (wid[1]),
    .i_ch3_delay   (dly[2]),
    .i_ch3_width   (wid[2]),
    .i_ch4_delay   (dly[3]),
    .i_ch4_width   (wid[3]),
    .o_do_trg      (do_trg),
    .o_do_ch1      (do_ch1),
    .o_do_ch2      (do_ch2),
    .o_do_ch3      (do_ch3),
    .o_do_ch4      (do_ch4),
    .o_do_interlock(do_ilk),
    .o_busy        (busy),
    .o_trg_cnt     (trg_cnt),
    .o_miss_cnt    (miss_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fire();
    beam = 1'b1;
    tick(3);
    beam = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
  endtask

  task automatic set_cfg(input int c, input int d, input int w);
    dly[c] = DW'(d);
    wid[c] = WW'(w);
  endtask

  // Reference model: a rising input sample at edge j yields an event visible after edge j+STG;
  // an accepted event at edge k opens an output window [k+D, k-1+D+W] and a busy window
  // [k, k-1+D+W]. Interlock or reset closes every window.
  longint      m_k = 0;
  longint      evq [$];
  bit          m_last = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_act [5];
  longint      m_ps [5];
  longint      m_pe [5];
  logic [31:0] m_trg = '0;
  logic [31:0] m_miss = '0;

  initial begin : ref_model
    logic          c_rstn, c_beam, c_en, c_ilk;
    logic [WW-1:0] c_tw;
    logic [DW-1:0] c_dly [4];
    logic [WW-1:0] c_wid [4];
    bit            ev_prev;
    longint        dd, ww;
    logic [4:0]    exp_p;
    logic [6:0]    exp_o;
    for (int c = 0; c < 5; c++) m_act[c] = 1'b0;
    forever begin
      @(posedge clk);
      m_k++;
      c_rstn = rstn;
      c_beam = beam;
      c_en   = en;
      c_ilk  = ilk;
      c_tw   = trg_w;
      c_dly  = dly;
      c_wid  = wid;
      #1;
      if (!c_rstn) begin
        evq.delete();
        m_last = 1'b0;
        m_trg  = '0;
        m_miss = '0;
        for (int c = 0; c < 5; c++) m_act[c] = 1'b0;
      end else begin
        while (evq.size() > 0 && evq[0] < m_k - 1) void'(evq.pop_front());
        ev_prev = (evq.size() > 0) && (evq[0] == m_k - 1);
        if (c_beam && !m_last) evq.push_back(m_k + STG);
        m_last = c_beam;
        if (force_req) begin
          m_trg     = '1;
          force_req = 1'b0;
        end
        if (c_ilk) begin
          for (int c = 0; c < 5; c++) m_act[c] = 1'b0;
        end else if (ev_prev && c_en) begin
          if (m_busy) begin
            m_miss++;
          end else begin
            m_trg++;
            for (int c = 0; c < 5; c++) begin
              if (c == 0) begin
                dd = 0;
                ww = longint'(c_tw);
              end else begin
                dd = longint'(c_dly[c-1]);
                ww = longint'(c_wid[c-1]);
              end
              if (ww != 0) begin
                m_act[c] = 1'b1;
                m_ps[c]  = m_k + dd;
                m_pe[c]  = m_k - 1 + dd + ww;
              end
            end
          end
        end
      end
      m_busy = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (m_act[c] && m_k > m_pe[c]) m_act[c] = 1'b0;
        exp_p[c] = m_act[c] && (m_k >= m_ps[c]);
        m_busy   = m_busy | m_act[c];
      end
      exp_o = {exp_p[0], exp_p[1], exp_p[2], exp_p[3], exp_p[4], c_rstn & c_ilk, m_busy};
      check("model_outputs", 64'({do_trg, do_ch1, do_ch2, do_ch3, do_ch4, do_ilk, busy}),
            64'(exp_o));
      check("model_trg_cnt", 64'(trg_cnt), 64'(m_trg));
      check("model_miss_cnt", 64'(miss_cnt), 64'(m_miss));
    end
  end

  typedef struct {
    int d;
    int w;
    int tw;
    int rise;      // first high cycle of ch1 relative to ev
    int len;
    bit busy_seen;
  } vec_t;

  initial begin : stim
    vec_t vt [6];
    int   first, hi1, hit, hi2, seen;
    bit   bsy;

    vt[0] = '{d: 10,   w: 20, tw: 4, rise: 11, len: 20, busy_seen: 1'b1};
    vt[1] = '{d: 0,    w: 1,  tw: 0, rise: 1,  len: 1,  busy_seen: 1'b1};
    vt[2] = '{d: 5,    w: 0,  tw: 0, rise: 0,  len: 0,  busy_seen: 1'b0};
    vt[3] = '{d: 1,    w: 3,  tw: 2, rise: 2,  len: 3,  busy_seen: 1'b1};
    vt[4] = '{d: 'h40, w: 7,  tw: 0, rise: 65, len: 7,  busy_seen: 1'b1};
    vt[5] = '{d: 2,    w: 1,  tw: 9, rise: 3,  len: 1,  busy_seen: 1'b1};

    for (int c = 0; c < 4; c++) set_cfg(c, 0, 0);
    tick(3);
    check("reset_outputs", 64'({do_trg, do_ch1, do_ch2, do_ch3, do_ch4, do_ilk, busy}), 64'd0);
    check("reset_counters", 64'({trg_cnt, miss_cnt}), 64'd0);
    rstn = 1'b1;
    en   = 1'b1;
    tick(2);

    // Table-driven single-trigger vectors on ch1 and the trigger channel.
    for (int i = 0; i < 6; i++) begin
      set_cfg(0, vt[i].d, vt[i].w);
      trg_w = WW'(vt[i].tw);
      tick(1);
      first = -1;
      hi1   = 0;
      hit   = 0;
      bsy   = 1'b0;
      beam  = 1'b1;
      for (int n = 1; n <= 200; n++) begin
        tick(1);
        if (n == 3) beam = 1'b0;
        if (do_ch1 && first < 0) first = n;
        hi1 += int'(do_ch1);
        hit += int'(do_trg);
        bsy |= busy;
      end
      if (vt[i].len > 0) check($sformatf("vec%0d_rise", i), 64'(first), 64'(STG + 1 + vt[i].rise));
      check($sformatf("vec%0d_len", i), 64'(hi1), 64'(vt[i].len));
      check($sformatf("vec%0d_trg_len", i), 64'(hit), 64'(vt[i].tw));
      check($sformatf("vec%0d_busy", i), 64'(bsy), 64'(vt[i].busy_seen));
      check($sformatf("vec%0d_trg_cnt", i), 64'(trg_cnt), 64'(i + 1));
    end

    // Second edge during a long delay is dropped and counted as a miss.
    do_reset();
    set_cfg(0, 0, 0);
    set_cfg(1, 100, 5);
    trg_w = '0;
    fire();
    tick(14);
    fire();
    hi2 = 0;
    for (int n = 0; n < 150; n++) begin
      tick(1);
      hi2 += int'(do_ch2);
    end
    check("retrig_ch2_len", 64'(hi2), 64'd5);
    check("retrig_trg_cnt", 64'(trg_cnt), 64'd1);
    check("retrig_miss_cnt", 64'(miss_cnt), 64'd1);

    // Interlock mid-pulse kills every output on the next edge and blocks counting.
    do_reset();
    set_cfg(0, 0, 50);
    set_cfg(1, 0, 0);
    trg_w = WW'(50);
    beam  = 1'b1;
    for (int n = 0; n < 20 && !do_ch1; n++) tick(1);
    check("ilk_pulse_started", 64'(do_ch1), 64'd1);
    beam = 1'b0;
    tick(5);
    ilk = 1'b1;
    tick(1);
    check("ilk_outputs_low", 64'({do_trg, do_ch1, do_ch2, do_ch3, do_ch4}), 64'd0);
    check("ilk_mirror", 64'(do_ilk), 64'd1);
    fire();
    tick(10);
    fire();
    tick(10);
    check("ilk_trg_cnt", 64'(trg_cnt), 64'd1);
    check("ilk_miss_cnt", 64'(miss_cnt), 64'd0);
    ilk  = 1'b0;
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      tick(1);
      seen += int'(do_ch1 | do_trg);
    end
    check("ilk_no_resume", 64'(seen), 64'd0);

    // Reset during a pending delay, with a trigger edge entirely inside reset.
    do_reset();
    set_cfg(0, 0, 0);
    set_cfg(1, 100, 5);
    trg_w = '0;
    fire();
    tick(20);
    check("rst_in_delay_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    beam = 1'b1;
    tick(1);
    check("rst_outputs", 64'({do_trg, do_ch1, do_ch2, do_ch3, do_ch4, do_ilk, busy}), 64'd0);
    check("rst_counters", 64'({trg_cnt, miss_cnt}), 64'd0);
    beam = 1'b0;
    tick(1);
    rstn = 1'b1;
    seen = 0;
    for (int n = 0; n < 200; n++) begin
      tick(1);
      seen += int'(do_ch2 | busy);
    end
    check("rst_no_pending_pulse", 64'(seen), 64'd0);
    check("rst_trg_cnt_after", 64'(trg_cnt), 64'd0);

    // Trigger counter wrap from all ones.
    do_reset();
    set_cfg(1, 0, 0);
    set_cfg(0, 0, 2);
    @(posedge clk);
    #2;
    force dut.trg_cnt_q = 32'hFFFF_FFFF;
    force_req = 1'b1;
    #1;
    release dut.trg_cnt_q;
    tick(1);
    check("wrap_preload_held", 64'(trg_cnt), 64'hFFFF_FFFF);
    fire();
    tick(5);
    check("wrap_trg_cnt", 64'(trg_cnt), 64'd0);

    // Randomized traffic; the reference model checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      if (n % 37 == 0) begin
        for (int c = 0; c < 4; c++) set_cfg(c, $urandom_range(0, 12), $urandom_range(0, 8));
        trg_w = WW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 5) == 0) beam = ~beam;
      en   = ($urandom_range(0, 15) != 0);
      ilk  = ($urandom_range(0, 99) < 3);
      rstn = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    rstn = 1'b1;
    ilk  = 1'b0;
    tick(40);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
    $finish;
  end

endmodule

// File: doc/trg_pulse_gen.md
TRG_PULSE_GEN -- requirements
Module: trg_pulse_gen

Interface
REQ-001 SHALL have parameter DLY_W, default 24, bit width of per-channel delay, in clock cycles.
REQ-002 SHALL have parameter WID_W, default 24, bit width of per-channel pulse width, in clock cycles.
REQ-003 SHALL have parameter SYNC_STG, default 2, number of synchronizer flops on i_beam_trg (minimum 2).
REQ-004 SHALL use one clock, i_clk, input, 1 bit: 200 MHz system clock (5 ns).
REQ-005 SHALL use reset i_rstn, input, 1 bit: synchronous, active-low.
REQ-006 i_beam_trg  input  1  asynchronous external beam trigger; rising edge is the event.
REQ-007 i_enable  input  1  global arm; when low, trigger events are ignored.
REQ-008 i_interlock  input  1  register-driven interlock; high forces all pulse outputs low.
REQ-009 i_trg_width  input  WID_W  o_do_trg pulse width.
REQ-010 i_chN_delay / i_chN_width (N=1..4)  input  DLY_W / WID_W  per-channel delay and width.
REQ-011 o_do_trg, o_do_ch1..o_do_ch4  output  1 each  generated pulses.
REQ-012 o_do_interlock  output  1  registered copy of i_interlock.
REQ-013 o_busy  output  1  OR of all channels not IDLE.
REQ-014 o_trg_cnt / o_miss_cnt  output  32 each  accepted / dropped trigger counters.

Function
REQ-015 i_beam_trg SHALL pass SYNC_STG flops, then a registered rising-edge detector producing a one-cycle event ev; ev asserts SYNC_STG+1 cycles after the input edge.
REQ-016 ev SHALL be accepted only when i_enable=1, i_interlock=0, and o_busy=0; an accepted ev increments o_trg_cnt.
REQ-017 ev SHALL be dropped and o_miss_cnt incremented when i_enable=1, i_interlock=0, and o_busy=1; with i_enable=0 or i_interlock=1, ev SHALL touch neither counter.
REQ-018 Counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-019 Each channel SHALL run an FSM with states IDLE, DELAY, PULSE.
REQ-020 On accepted ev, each channel SHALL latch its delay D and width W; if W=0, the channel SHALL stay IDLE.
REQ-021 If D=0, the FSM SHALL go IDLE->PULSE; otherwise it SHALL go IDLE->DELAY, stay D cycles, then go to PULSE.
REQ-022 The output SHALL be high exactly W cycles in PULSE, rising at cycle ev+1+D, then the FSM SHALL return to IDLE.
REQ-023 Register changes during DELAY or PULSE SHALL NOT affect the running pulse.
REQ-024 o_do_trg SHALL be a channel with D fixed at 0 and W=i_trg_width.
REQ-025 i_interlock=1 SHALL force all channels to IDLE and all pulse outputs to 0 on the next clock, including mid-pulse; there SHALL be no resume after interlock release.
REQ-026 Pulse outputs SHALL be registered, with no combinational path from inputs.
REQ-027 Maximum D and W (all ones) SHALL work without overflow, with the down-counter sized to the parameter width.

Reset
REQ-028 While i_rstn=0 at a clock edge, all FSMs SHALL be IDLE; all outputs, counters, and synchronizer flops SHALL be 0.
REQ-029 Reset asserted mid-pulse SHALL drop the output on that edge.
REQ-030 A trigger edge present during reset SHALL NOT produce ev after release, because the edge detector history is held at 0.

Structure
REQ-031 The per-channel FSM+counter SHALL be sub-module do_pulse_ch, instantiated 5 times (trg, ch1..ch4).
REQ-032 FSM state encoding and default DLY_W/WID_W SHALL reside in shared package trbds3_dio_pkg.
REQ-033 The block SHALL sit between the DIO AXI register block (config source) and the o_do_* pins.

Verification
REQ-034 Bench: D=10, W=20 on ch1, i_enable=1, trigger edge -> o_do_ch1 high from ev+11 for 20 cycles; o_trg_cnt=1.
REQ-035 Bench: D=0, W=1 -> one-cycle pulse at ev+1; W=0 -> no pulse, o_busy stays 0 for that channel.
REQ-036 Bench: second edge while ch2 in DELAY (D=100) -> no retrigger; o_miss_cnt=1, o_trg_cnt=1.
REQ-037 Bench: i_interlock raised mid-PULSE -> all o_do_* 0 next cycle; o_do_interlock=1; later edges while interlocked -> no counter change.
REQ-038 Bench: i_rstn low mid-DELAY -> outputs and counters 0; after release, the pending delay never produces a pulse.
REQ-039 Bench: o_trg_cnt preloaded by forcing to 0xFFFFFFFF, one accepted edge -> o_trg_cnt=0.
